ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-port round-robin arbiter and sequencer for the single-port synchronous RAM (Single_sync_RAM, ADDR_PIPELINE="FALSE", DOUT_PIPELINE="TRUE"). It accepts read/write requests from two independent requesters and issues at most one RAM command per cycle. It tracks in-flight reads through the RAM's output pipeline and returns each read word, with its parity, to the requester that issued it.

## Interface
Parameters:
- MEM_WIDTH, 16, data width; must match the RAM.
- ADDR_SIZE, 10, address width; must match the RAM.
- MEM_DEPTH, 1024, number of words; used by the init sweep.
- RD_LATENCY, 2, cycles from RAM command cycle to valid ram_dout; 2 for DOUT_PIPELINE="TRUE".

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request valid, port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_SIZE  request address
- wdata0 / wdata1  in  MEM_WIDTH  write data
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for the port
- rdata  out  MEM_WIDTH  read data, shared by both ports and qualified by rvalidN
- rparity  out  1  RAM parity_out, aligned with rdata
- init_done  out  1  controller accepts requests
- ram_blk_select, ram_addr_en, ram_dout_en  out  1  RAM controls
- ram_wr_en, ram_rd_en  out  1  RAM command strobes (registered)
- ram_addr  out  ADDR_SIZE;  ram_din  out  MEM_WIDTH  (registered)
- ram_dout  in  MEM_WIDTH;  ram_parity  in  1  from RAM

## Operation
- Handshake: requester holds req/we/addr/wdata stable until it samples gntN=1. One accept per cycle maximum.
- gntN is 0 whenever init_done=0.
- Arbitration is round-robin:
  - One requester active: it wins.
  - Both active: the port not granted last wins.
  - Last-grant pointer updates only on a grant; reset value favours port 0.
- Accepted request is loaded into the command registers (ram_wr_en=we, ram_rd_en=~we, ram_addr, ram_din). Strobes are high for exactly one cycle.
- ram_blk_select, ram_addr_en, ram_dout_en are held at 1 after reset. The RAM output pipeline therefore always advances.
- Each issued read pushes {valid, port id} into a tag shift register of depth RD_LATENCY. At the tail, rvalid of the tagged port asserts with rdata=ram_dout and rparity=ram_parity.
- Back-to-back reads from mixed ports return in issue order, one per cycle.
- Write then read of the same address in consecutive accepted cycles returns the new data, because the RAM writes on the earlier edge.
- States are INIT and RUN. Without init, the controller goes directly to RUN.
- Reset values:
  - All gnt, rvalid, ram_wr_en and ram_rd_en are 0.
  - ram_addr, ram_din, rdata and rparity are 0.
  - The tag pipeline is cleared.
  - ram_blk_select, ram_addr_en and ram_dout_en are 0 during reset and 1 from the first edge after reset release.
  - init_done is 0 during reset.
- Reset mid-operation drops all in-flight reads; no rvalid appears for them.

## Timing
- Cycle c: gntN=1. Cycle c+1: RAM strobe active. Cycle c+1+RD_LATENCY: rvalidN=1 for that read (c+3 at default).
- Throughput: one command per cycle. Sustained dual requests alternate grants P0, P1, P0, ...
- Writes produce no response. Write data is in the RAM after the edge ending cycle c+1.

## Configuration
- Macro RAM_ARB_INIT_EN.
- Defined:
  - After reset release the controller enters INIT and writes 0 to addresses 0..MEM_DEPTH-1, one per cycle, using ram_wr_en.
  - init_done rises the cycle after the last write and stays 1 until reset.
  - Requests are ignored during INIT.
  - Reset during INIT restarts the sweep at address 0.
- Undefined: no INIT state; init_done=1 from the first edge after reset release.

## Structure
- Package ram_arb_pkg holds:
  - state enum {INIT, RUN}
  - port-id typedef (1 bit)
  - tag struct {valid, id}
  - default RD_LATENCY constant
- One sub-module: rr_arb2, the combinational two-way round-robin grant with its registered last-grant pointer.

## Test plan
- Reset, then read addr 5 on port 0 (no prior write) -> gnt0 at cycle c, rvalid0 at c+3, rdata=0 with RAM_ARB_INIT_EN, rparity=0.
- Port 0 writes 0x00FF to addr 10, then port 1 reads addr 10 -> rvalid1 at 3 cycles after gnt1, rdata=0x00FF, rparity=0.
- req0 and req1 held high with reads to addrs 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1; rvalid pattern matches grants 3 cycles later.
- Port 1 writes 0xA5A5 to addr 3, immediately followed by port 0 reading addr 3 -> rdata=0xA5A5, rvalid0 only.
- Assert rst while two reads are in flight -> no rvalid for either; all outputs at reset values.
- RAM_ARB_INIT_EN with MEM_DEPTH=16 -> 16 ram_wr_en cycles at addresses 0..15 with ram_din=0; init_done rises next cycle; no gnt before then.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: controller states, port ids
// and the read-tag entry carried through the RAM output pipeline.
package ram_arb_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t id;
  } tag_t;

  localparam int DEFAULT_RD_LATENCY = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: two request ports plus the shared
// read-return bus. master = requesters, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADDR_SIZE = 10
);

  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDR_SIZE-1:0] addr0;
  logic [ADDR_SIZE-1:0] addr1;
  logic [MEM_WIDTH-1:0] wdata0;
  logic [MEM_WIDTH-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic [MEM_WIDTH-1:0] rdata;
  logic                 rparity;
  logic                 init_done;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rparity, init_done
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rparity, init_done
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant from the requests and a
// registered last-grant pointer that only moves when a grant is issued.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // 1 means port 1 was granted last; reset value lets port 0 win a tie.
  logic last_p1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last_p1;
        gnt1 = ~last_p1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p1 <= 1'b1;
    end else if (gnt0) begin
      last_p1 <= 1'b0;
    end else if (gnt1) begin
      last_p1 <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sequencer for Single_sync_RAM with tagged read return.
// Define RAM_ARB_INIT_EN to zero the whole RAM after reset before serving requests.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WIDTH  = 16,
  parameter int ADDR_SIZE  = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    rif,
  output logic                 ram_blk_select,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

`ifdef RAM_ARB_INIT_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  state_e               state;
  logic [ADDR_SIZE-1:0] init_addr;
  logic                 init_done_q;
  logic                 gnt0;
  logic                 gnt1;
  port_id_t             cmd_id;
  tag_t                 tag_pipe [RD_LATENCY];
  tag_t                 tail;

  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [MEM_WIDTH-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (init_done_q),
    .req0 (rif.req0),
    .req1 (rif.req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign sel_we    = gnt1 ? rif.we1    : rif.we0;
  assign sel_addr  = gnt1 ? rif.addr1  : rif.addr0;
  assign sel_wdata = gnt1 ? rif.wdata1 : rif.wdata0;

  // init_done lags the RUN transition by one cycle so it rises after the last sweep write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RESET_STATE;
      init_addr      <= '0;
      init_done_q    <= 1'b0;
      ram_blk_select <= 1'b0;
      ram_addr_en    <= 1'b0;
      ram_dout_en    <= 1'b0;
      ram_wr_en      <= 1'b0;
      ram_rd_en      <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      cmd_id         <= 1'b0;
    end else begin
      ram_blk_select <= 1'b1;
      ram_addr_en    <= 1'b1;
      ram_dout_en    <= 1'b1;
      init_done_q    <= (state == RUN);
      ram_wr_en      <= 1'b0;
      ram_rd_en      <= 1'b0;
      case (state)
        INIT: begin
          ram_wr_en <= 1'b1;
          ram_addr  <= init_addr;
          ram_din   <= '0;
          if (init_addr == LAST_ADDR) begin
            state <= RUN;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        default: begin
          if (gnt0 || gnt1) begin
            ram_wr_en <= sel_we;
            ram_rd_en <= ~sel_we;
            ram_addr  <= sel_addr;
            ram_din   <= sel_wdata;
            cmd_id    <= gnt1;
          end
        end
      endcase
    end
  end

  // Tag enters alongside the read strobe; its tail lines up with ram_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: ram_rd_en, id: cmd_id};
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tail          = tag_pipe[RD_LATENCY-1];
  assign rif.gnt0      = gnt0;
  assign rif.gnt1      = gnt1;
  assign rif.rvalid0   = tail.valid & ~tail.id;
  assign rif.rvalid1   = tail.valid & tail.id;
  assign rif.rdata     = tail.valid ? ram_dout : '0;
  assign rif.rparity   = tail.valid & ram_parity;
  assign rif.init_done = init_done_q;

endmodule
